// File: rtl/bram_ctrl_pkg.sv
// Shared helpers and types for the BRAM port request controller and its response FIFO.
package bram_ctrl_pkg;

   typedef enum logic {
      REQ_READ  = 1'b0,
      REQ_WRITE = 1'b1
   } req_kind_e;

   localparam int DEF_ADDR_WIDTH = 9;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_PIPELINED  = 0;
   localparam int DEF_RESP_DEPTH = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // BRAM read latency: the optional output register adds one cycle.
   function automatic int lat_of(input int pipelined);
      return (pipelined != 0) ? 2 : 1;
   endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Small synchronous response FIFO with a registered head word (dout always shows the oldest entry).
module bram_resp_fifo
   import bram_ctrl_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int DEPTH      = DEF_RESP_DEPTH,
   localparam int PTR_W      = clog2(DEPTH),
   localparam int CNT_W      = clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_W-1:0]      count
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      rd_next;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  pop_ok;

   assign pop_ok  = pop & (count_q != '0);
   assign rd_next = rd_ptr_q + PTR_W'(1);

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop_ok);
      dout_d   = dout_q;
      // The head register refills from the array, or straight from din when the
      // pushed word becomes the new head (FIFO empty, or last entry leaving).
      if (pop_ok && (count_q > CNT_W'(1))) begin
         dout_d = mem_q[rd_next];
      end else if (push && ((count_q == '0) || (pop_ok && (count_q == CNT_W'(1))))) begin
         dout_d = din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = dout_q;
   assign count = count_q;
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/bram_port_req_ctrl.sv
// Valid/ready front-end for one BRAM port: drives EN/WE/ADDR/DI, tracks read latency,
// and queues returning words in a credit-protected response FIFO.
module bram_port_req_ctrl
   import bram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PIPELINED  = DEF_PIPELINED,
   parameter int RESP_DEPTH = DEF_RESP_DEPTH
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  bram_en,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_wdata,
   input  logic [DATA_WIDTH-1:0] bram_rdata
);

   localparam int LAT   = lat_of(PIPELINED);
   localparam int CNT_W = clog2(RESP_DEPTH + 1);

   logic             active_q, active_d;
   logic [LAT-1:0]   vld_q, vld_d;
   logic [CNT_W-1:0] inflight_cnt;
   logic [CNT_W-1:0] fifo_cnt;
   logic             fifo_full;
   logic             fifo_empty;
   logic             is_write;
   logic             credit_ok;
   logic             rd_accept;
   logic             push;
   logic             pop;

   assign is_write = (req_kind_e'(req_write) == REQ_WRITE);

   always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight_cnt = inflight_cnt + CNT_W'(vld_q[i]);
      end
   end

   // Every read in flight or already queued holds one FIFO slot, so a push never finds it full.
   assign credit_ok = ({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < (CNT_W + 1)'(RESP_DEPTH);
   assign req_ready = active_q & (is_write | credit_ok);

   assign bram_en    = req_valid & req_ready;
   assign bram_we    = is_write & bram_en;
   assign bram_addr  = req_addr;
   assign bram_wdata = req_wdata;
   assign rd_accept  = bram_en & ~is_write;

   generate
      if (LAT == 1) begin : g_lat1
         assign vld_d = rd_accept;
      end else begin : g_latn
         assign vld_d = {vld_q[LAT-2:0], rd_accept};
      end
   endgenerate

   assign active_d = 1'b1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         active_q <= 1'b0;
         vld_q    <= '0;
      end else begin
         active_q <= active_d;
         vld_q    <= vld_d;
      end
   end

   assign push       = vld_q[LAT-1];
   assign resp_valid = ~fifo_empty;
   assign pop        = resp_valid & resp_ready;

   bram_resp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RESP_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (push),
      .din   (bram_rdata),
      .pop   (pop),
      .dout  (resp_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

   a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_bram_port_req_ctrl.sv
// Scoreboard bench for bram_port_req_ctrl with a write-first BRAM model behind it.
module tb_bram_port_req_ctrl;

   localparam int AW        = 9;
   localparam int DW        = 32;
   localparam int PIPELINED = 1;
   localparam int DEPTH     = 4;
   localparam int LAT       = 1 + PIPELINED;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [DW-1:0] resp_data;
   logic          bram_en;
   logic          bram_we;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_wdata;
   logic [DW-1:0] bram_rdata;

   int            n_checks = 0;
   int            n_fail = 0;
   int            resp_seen = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] ref_mem [512];

   always #5 CLK = ~CLK;

   bram_port_req_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .PIPELINED  (PIPELINED),
      .RESP_DEPTH (DEPTH)
   ) u_dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .bram_en    (bram_en),
      .bram_we    (bram_we),
      .bram_addr  (bram_addr),
      .bram_wdata (bram_wdata),
      .bram_rdata (bram_rdata)
   );

   // Write-first BRAM with optional output register.
   logic [DW-1:0] bmem [512];
   logic [DW-1:0] do_s1, do_s2;
   always @(posedge CLK) begin
      if (bram_en) begin
         if (bram_we) begin
            bmem[bram_addr] <= bram_wdata;
            do_s1 <= bram_wdata;
         end else begin
            do_s1 <= bmem[bram_addr];
         end
      end
      do_s2 <= do_s1;
   end
   assign bram_rdata = (PIPELINED != 0) ? do_s2 : do_s1;

   // Response monitor: every handshake pops the scoreboard.
   always begin
      @(negedge CLK);
      #3;
      if (RST_N && resp_valid && resp_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL resp_unexpected: got %h, scoreboard empty", resp_data);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (resp_data !== e) begin
               n_fail++;
               $display("FAIL resp_data: got %h, expected %h", resp_data, e);
            end else begin
               $display("resp %0d: data %h ok", resp_seen, resp_data);
            end
         end
         resp_seen++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycle_drive(input logic v, input logic w, input int a, input logic [DW-1:0] d,
                              input logic rr, output logic acc);
      @(negedge CLK);
      req_valid  = v;
      req_write  = w;
      req_addr   = AW'(a);
      req_wdata  = d;
      resp_ready = rr;
      #1;
      acc = v & req_ready;
      if (acc) begin
         if (w) ref_mem[a] = d;
         else   exp_q.push_back(ref_mem[a]);
      end
   endtask

   task automatic fill(input int base, input int n);
      logic acc;
      for (int i = 0; i < n; i++) cycle_drive(1'b1, 1'b1, base + i, $urandom, 1'b1, acc);
      repeat (LAT + 3) cycle_drive(1'b0, 1'b0, 0, '0, 1'b1, acc);
   endtask

   task automatic test_reset();
      req_valid = 1'b1; req_write = 1'b1; resp_ready = 1'b1;
      #2 RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      #1;
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b, expected 0", req_ready); end
      n_checks++; if (bram_en !== 1'b0) begin n_fail++; $display("FAIL reset_bram_en: got %b, expected 0", bram_en); end
      n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL reset_bram_we: got %b, expected 0", bram_we); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b, expected 0", resp_valid); end
      n_checks++; if (resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data: got %h, expected 0", resp_data); end
      req_valid = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);
      $display("test_reset done");
   endtask

   task automatic test_write_read();
      logic acc;
      int   first, base;
      logic [DW-1:0] got;
      first = -1; got = '0;
      cycle_drive(1'b1, 1'b1, 5, 32'hDEADBEEF, 1'b1, acc);
      n_checks++; if (acc !== 1'b1 || bram_we !== 1'b1 || bram_addr !== AW'(5) || bram_wdata !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL wr_drive: acc %b we %b addr %0d di %h, expected 1 1 5 deadbeef", acc, bram_we, bram_addr, bram_wdata);
      end
      cycle_drive(1'b1, 1'b0, 5, '0, 1'b1, acc);
      n_checks++; if (acc !== 1'b1 || bram_en !== 1'b1 || bram_we !== 1'b0) begin
         n_fail++; $display("FAIL rd_drive: acc %b en %b we %b, expected 1 1 0", acc, bram_en, bram_we);
      end
      base = resp_seen;
      for (int c = 2; c < 12; c++) begin
         cycle_drive(1'b0, 1'b0, 0, '0, 1'b1, acc);
         if (first < 0 && resp_valid === 1'b1) begin first = c; got = resp_data; end
      end
      n_checks++; if (first != LAT + 2) begin n_fail++; $display("FAIL wr_rd_latency: resp_valid at cycle %0d, expected %0d", first, LAT + 2); end
      n_checks++; if (got !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_data: got %h, expected deadbeef", got); end
      n_checks++; if (resp_seen - base != 1) begin n_fail++; $display("FAIL wr_rd_count: got %0d responses, expected 1", resp_seen - base); end
      $display("test_write_read done");
   endtask

   task automatic test_back_to_back();
      logic acc, exp_v;
      int   base;
      fill(0, 16);
      base = resp_seen;
      for (int c = 0; c < 16 + LAT + 4; c++) begin
         if (c < 16) cycle_drive(1'b1, 1'b0, c, '0, 1'b1, acc);
         else        cycle_drive(1'b0, 1'b0, 0, '0, 1'b1, acc);
         if (c < 16) begin
            n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: read %0d acc %b, expected 1", c, acc); end
         end
         exp_v = (c >= LAT + 1) && (c < LAT + 17);
         n_checks++; if (resp_valid !== exp_v) begin n_fail++; $display("FAIL b2b_resp_valid: cycle %0d got %b, expected %b", c, resp_valid, exp_v); end
      end
      n_checks++; if (resp_seen - base != 16) begin n_fail++; $display("FAIL b2b_count: got %0d, expected 16", resp_seen - base); end
      $display("test_back_to_back done");
   endtask

   task automatic test_backpressure();
      logic acc;
      int   nacc, base;
      fill(16, 8);
      nacc = 0;
      base = resp_seen;
      for (int c = 0; c < 10; c++) begin
         cycle_drive(1'b1, 1'b0, 16 + nacc, '0, 1'b0, acc);
         if (acc) nacc++;
      end
      n_checks++; if (nacc != DEPTH) begin n_fail++; $display("FAIL bp_accepted: got %0d, expected %0d", nacc, DEPTH); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b, expected 0", req_ready); end
      cycle_drive(1'b0, 1'b0, 0, '0, 1'b1, acc);
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_pop_cycle: got %b, expected 0", req_ready); end
      cycle_drive(1'b0, 1'b0, 0, '0, 1'b1, acc);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b, expected 1", req_ready); end
      for (int c = 0; c < 8; c++) cycle_drive(1'b0, 1'b0, 0, '0, 1'b1, acc);
      n_checks++; if (resp_seen - base != DEPTH) begin n_fail++; $display("FAIL bp_drain: got %0d, expected %0d", resp_seen - base, DEPTH); end
      $display("test_backpressure done");
   endtask

   task automatic test_full_push_pop();
      logic acc, rr;
      int   issued, base;
      fill(64, 32);
      issued = 0;
      base = resp_seen;
      for (int c = 0; c < 10 && issued < DEPTH; c++) begin
         cycle_drive(1'b1, 1'b0, 64 + issued, '0, 1'b0, acc);
         if (acc) issued++;
      end
      repeat (LAT + 2) cycle_drive(1'b0, 1'b0, 0, '0, 1'b0, acc);
      for (int c = 0; c < 40; c++) begin
         rr = (c < 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
         cycle_drive(1'b1, 1'b0, 64 + (issued % 32), '0, rr, acc);
         if (acc) issued++;
      end
      for (int c = 0; c < 20; c++) cycle_drive(1'b0, 1'b0, 0, '0, 1'b1, acc);
      n_checks++; if (resp_seen - base != issued) begin n_fail++; $display("FAIL fpp_count: got %0d, expected %0d", resp_seen - base, issued); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fpp_leftover: %0d outstanding, expected 0", exp_q.size()); end
      $display("test_full_push_pop done: %0d reads", issued);
   endtask

   task automatic test_reset_midstream();
      logic acc;
      int   base, stale;
      logic [DW-1:0] val;
      fill(96, 4);
      for (int c = 0; c < 4; c++) cycle_drive(1'b1, 1'b0, 96 + c, '0, 1'b0, acc);
      @(negedge CLK);
      req_valid = 1'b0;
      #2 RST_N = 1'b0;
      #1;
      exp_q.delete();
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_resp_valid: got %b, expected 0", resp_valid); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req_ready: got %b, expected 0", req_ready); end
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      stale = 0;
      for (int c = 0; c < 8; c++) begin
         cycle_drive(1'b0, 1'b0, 0, '0, 1'b1, acc);
         if (resp_valid !== 1'b0) stale++;
      end
      n_checks++; if (stale != 0) begin n_fail++; $display("FAIL rst_mid_stale: %0d cycles with resp_valid, expected 0", stale); end
      base = resp_seen;
      val = $urandom;
      cycle_drive(1'b1, 1'b1, 100, val, 1'b1, acc);
      cycle_drive(1'b1, 1'b0, 100, '0, 1'b1, acc);
      for (int c = 0; c < 10; c++) cycle_drive(1'b0, 1'b0, 0, '0, 1'b1, acc);
      n_checks++; if (resp_seen - base != 1) begin n_fail++; $display("FAIL rst_mid_fresh: got %0d responses, expected 1", resp_seen - base); end
      $display("test_reset_midstream done");
   endtask

   task automatic test_write_then_read();
      logic acc_w, acc_r, acc;
      logic [DW-1:0] val, got;
      int   base;
      logic seen;
      val = $urandom; got = '0; seen = 1'b0;
      base = resp_seen;
      cycle_drive(1'b1, 1'b1, 7, val, 1'b1, acc_w);
      cycle_drive(1'b1, 1'b0, 7, '0, 1'b1, acc_r);
      n_checks++; if (acc_w !== 1'b1 || acc_r !== 1'b1) begin n_fail++; $display("FAIL wtr_accept: w %b r %b, expected 1 1", acc_w, acc_r); end
      for (int c = 0; c < 10; c++) begin
         cycle_drive(1'b0, 1'b0, 0, '0, 1'b1, acc);
         if (!seen && resp_valid === 1'b1) begin seen = 1'b1; got = resp_data; end
      end
      n_checks++; if (got !== val) begin n_fail++; $display("FAIL wtr_data: got %h, expected %h", got, val); end
      n_checks++; if (resp_seen - base != 1) begin n_fail++; $display("FAIL wtr_count: got %0d, expected 1", resp_seen - base); end
      $display("test_write_then_read done");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_backpressure();
      test_full_push_pop();
      test_reset_midstream();
      test_write_then_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
